// File: rtl/flt_stat_bank_pkg.sv
// flt_stat_bank_pkg: interrupt FSM states and address-decode helpers for the fault status bank.
package flt_stat_bank_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HOLD} flt_intb_st_e;
    localparam int ST_BASE = 0;
    function automatic int mask_base(input int num_reg);
        return num_reg;
    endfunction
    function automatic int addr_lim(input int num_reg);
        return 2 * num_reg;
    endfunction
endpackage

// File: rtl/flt_stat_bank_filt.sv
// flt_filt: single-bit debounce; passes a fault once it has been high FILT_CYC consecutive cycles.
module flt_filt #(
    parameter int unsigned FILT_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);
    if (FILT_CYC == 0) begin : g_bypass
        assign filt_o = raw_i;
    end else begin : g_cnt
        localparam int unsigned CW = $clog2(FILT_CYC + 1);
        localparam logic [CW-1:0] SAT = CW'(FILT_CYC);
        logic [CW-1:0] cnt_q, cnt_d;
        always_comb cnt_d = !raw_i ? '0 : (cnt_q == SAT) ? cnt_q : cnt_q + 1'b1;
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt_q <= '0;
            else cnt_q <= cnt_d;
        // The current high cycle counts toward the threshold, so status sets on the FILT_CYC-th edge.
        assign filt_o = raw_i && (cnt_d == SAT);
    end
endmodule

// File: rtl/flt_stat_bank.sv
// flt_stat_bank: debounced sticky W1C fault status, mask registers, register access path
// and an active-low interrupt with a guaranteed minimum low pulse.
module flt_stat_bank
    import flt_stat_bank_pkg::*;
#(
    parameter int unsigned NUM_REG = 2,
    parameter int unsigned REG_DW = 8,
    parameter int unsigned FILT_CYC = 3,
    parameter int unsigned INTB_MIN_CYC = 4,
    parameter logic [NUM_REG*REG_DW-1:0] MASK_RST = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REG*REG_DW-1:0]     fault_raw,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [$clog2(2*NUM_REG)-1:0]  addr,
    input  logic [REG_DW-1:0]             wdata,
    output logic [REG_DW-1:0]             rdata,
    output logic                          rvalid,
    output logic                          addr_err,
    output logic [NUM_REG*REG_DW-1:0]     status,
    output logic                          flt_pend,
    output logic                          intb_o
);
    localparam int unsigned NB = NUM_REG * REG_DW;
    localparam int unsigned CW = $clog2(INTB_MIN_CYC + 1);
    logic [NB-1:0] filt, status_q, status_d, mask_q, mask_d;
    logic [REG_DW-1:0] rdata_q, rd_val;
    logic rvalid_q, addr_err_q, unmapped, tc;
    logic [CW-1:0] cnt_q, cnt_d;
    flt_intb_st_e st_q, st_d;
    int a;

    for (genvar i = 0; i < NB; i++) begin : g_filt
        flt_filt #(.FILT_CYC(FILT_CYC)) u_filt (
            .clk(clk), .rst(rst), .raw_i(fault_raw[i]), .filt_o(filt[i])
        );
    end

    assign a = int'(addr);
    assign unmapped = a >= addr_lim(NUM_REG);

    always_comb begin
        status_d = status_q;
        mask_d = mask_q;
        rd_val = '0;
        for (int r = 0; r < NUM_REG; r++) begin
            if (wr_en && a == ST_BASE + r) status_d[r*REG_DW +: REG_DW] = status_q[r*REG_DW +: REG_DW] & ~wdata;
            if (wr_en && a == mask_base(NUM_REG) + r) mask_d[r*REG_DW +: REG_DW] = wdata;
            if (a == ST_BASE + r) rd_val = status_q[r*REG_DW +: REG_DW];
            if (a == mask_base(NUM_REG) + r) rd_val = mask_q[r*REG_DW +: REG_DW];
        end
        // Applying set after clear makes a simultaneous set win.
        status_d = status_d | filt;
    end

    assign tc = cnt_q == CW'(INTB_MIN_CYC - 1);

    always_comb begin
        st_d = st_q;
        cnt_d = '0;
        case (st_q)
            IDLE: st_d = flt_pend ? LOW : IDLE;
            LOW: begin
                st_d = !tc ? LOW : flt_pend ? HOLD : IDLE;
                cnt_d = tc ? '0 : cnt_q + 1'b1;
            end
            HOLD: st_d = flt_pend ? HOLD : IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
            mask_q <= MASK_RST;
            rdata_q <= '0;
            rvalid_q <= 1'b0;
            addr_err_q <= 1'b0;
            st_q <= IDLE;
            cnt_q <= '0;
        end else begin
            status_q <= status_d;
            mask_q <= mask_d;
            rdata_q <= rd_en ? rd_val : rdata_q;
            rvalid_q <= rd_en;
            addr_err_q <= (rd_en || wr_en) && unmapped;
            st_q <= st_d;
            cnt_q <= cnt_d;
        end
    end

    assign flt_pend = |(status_q & ~mask_q);
    assign intb_o = st_q == IDLE;
    assign status = status_q;
    assign rdata = rdata_q;
    assign rvalid = rvalid_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_flt_stat_bank.sv
// tb_flt_stat_bank: directed checks of filtering, W1C status, masking, reads and interrupt pulse width.
module tb_flt_stat_bank;
    logic clk = 1'b0, rst = 1'b1;
    logic [15:0] fault_raw = '0, status;
    logic wr_en = 1'b0, rd_en = 1'b0, rvalid, addr_err, flt_pend, intb_o;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0, rdata;
    logic [23:0] fault_raw3 = '0, status3;
    logic wr_en3 = 1'b0, rd_en3 = 1'b0, rvalid3, addr_err3, flt_pend3, intb3;
    logic [2:0] addr3 = '0;
    logic [7:0] wdata3 = '0, rdata3;
    int vecs = 0, errs = 0, n;

    always #5 clk = ~clk;

    flt_stat_bank dut (
        .clk(clk), .rst(rst), .fault_raw(fault_raw), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .addr_err(addr_err), .status(status),
        .flt_pend(flt_pend), .intb_o(intb_o)
    );

    flt_stat_bank #(.NUM_REG(3), .MASK_RST(24'h0000F0)) dut3 (
        .clk(clk), .rst(rst), .fault_raw(fault_raw3), .wr_en(wr_en3), .rd_en(rd_en3), .addr(addr3),
        .wdata(wdata3), .rdata(rdata3), .rvalid(rvalid3), .addr_err(addr_err3), .status(status3),
        .flt_pend(flt_pend3), .intb_o(intb3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && !intb_o; i++) step();
        chk(tag, intb_o, 1'b1);
    endtask

    initial begin
        #12;
        chk("rst_status", status, 16'h0);
        chk("rst_pend", flt_pend, 1'b0);
        chk("rst_intb", intb_o, 1'b1);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_addr_err", addr_err, 1'b0);
        rst = 1'b0;
        // 2-cycle glitch must be rejected
        fault_raw[0] = 1'b1;
        repeat (2) step();
        fault_raw[0] = 1'b0;
        step();
        chk("glitch_status", status, 16'h0);
        chk("glitch_intb", intb_o, 1'b1);
        fault_raw[0] = 1'b1;
        repeat (3) step();
        fault_raw[0] = 1'b0;
        chk("filt3_status", status, 16'h0001);
        chk("filt3_pend", flt_pend, 1'b1);
        chk("filt3_intb_pre", intb_o, 1'b1);
        step();
        chk("filt3_intb_fall", intb_o, 1'b0);
        // clear one cycle into LOW: pulse still lasts the minimum 4 cycles
        wr(2'd0, 8'h01);
        chk("min_clr_status", status, 16'h0);
        chk("min_low2", intb_o, 1'b0);
        step();
        chk("min_low3", intb_o, 1'b0);
        step();
        chk("min_low4", intb_o, 1'b0);
        step();
        chk("min_release", intb_o, 1'b1);
        // status[9]: register 1 bit 1
        fault_raw[9] = 1'b1;
        repeat (3) step();
        fault_raw[9] = 1'b0;
        chk("s9_set", status, 16'h0200);
        step();
        chk("s9_intb_fall", intb_o, 1'b0);
        wr(2'd1, 8'h02);
        chk("s9_clr", status, 16'h0);
        chk("s9_low2", intb_o, 1'b0);
        step();
        chk("s9_low3", intb_o, 1'b0);
        step();
        chk("s9_low4", intb_o, 1'b0);
        step();
        chk("s9_release", intb_o, 1'b1);
        fault_raw[9] = 1'b1;
        repeat (3) step();
        chk("s9_reset", status, 16'h0200);
        wr(2'd1, 8'h02);
        chk("s9_clr_blocked", status, 16'h0200);
        fault_raw[9] = 1'b0;
        wr(2'd1, 8'h02);
        chk("s9_clr_after_drop", status, 16'h0);
        wait_idle("s9_idle");
        // masked fault latches but does not interrupt
        wr(2'd2, 8'hFF);
        fault_raw[3] = 1'b1;
        repeat (3) step();
        fault_raw[3] = 1'b0;
        chk("mask_status", status, 16'h0008);
        chk("mask_pend", flt_pend, 1'b0);
        step();
        chk("mask_intb", intb_o, 1'b1);
        wr(2'd2, 8'h00);
        chk("unmask_pend", flt_pend, 1'b1);
        chk("unmask_intb_pre", intb_o, 1'b1);
        step();
        chk("unmask_intb_fall", intb_o, 1'b0);
        // pending held 10 cycles after the fall: 11-cycle low pulse via HOLD
        n = 1;
        repeat (9) begin
            step();
            if (!intb_o) n++;
        end
        wr(2'd0, 8'h08);
        if (!intb_o) n++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (intb_o) break;
            n++;
        end
        chk("hold_low_cycles", n, 11);
        chk("hold_idle", intb_o, 1'b1);
        // read and write same address in one cycle returns the pre-write value
        fault_raw[0] = 1'b1; fault_raw[2] = 1'b1;
        repeat (3) step();
        fault_raw = '0;
        chk("rw_pre_status", status, 16'h0005);
        rd_en = 1'b1;
        wr(2'd0, 8'hFF);
        rd_en = 1'b0;
        chk("rw_rdata", rdata, 8'h05);
        chk("rw_rvalid", rvalid, 1'b1);
        chk("rw_addr_err", addr_err, 1'b0);
        chk("rw_status_after", status, 16'h0);
        step();
        chk("rw_rvalid_pulse", rvalid, 1'b0);
        wait_idle("rw_idle");
        wr(2'd3, 8'hA5);
        rd(2'd3);
        chk("mask1_read", rdata, 8'hA5);
        chk("mask1_pend", flt_pend, 1'b0);
        wr(2'd3, 8'h00);
        // unmapped addresses on a 3-register bank
        rd_en3 = 1'b1; addr3 = 3'd3;
        step();
        chk("d3_mask_rst", rdata3, 8'hF0);
        wr_en3 = 1'b1; rd_en3 = 1'b0; wdata3 = 8'h3C;
        step();
        wr_en3 = 1'b0; rd_en3 = 1'b1; addr3 = 3'd6;
        step();
        rd_en3 = 1'b0;
        chk("d3_unmapped_rdata", rdata3, 8'h00);
        chk("d3_unmapped_rvalid", rvalid3, 1'b1);
        chk("d3_rd_addr_err", addr_err3, 1'b1);
        wr_en3 = 1'b1; addr3 = 3'd7; wdata3 = 8'hFF;
        step();
        wr_en3 = 1'b0;
        chk("d3_wr_addr_err", addr_err3, 1'b1);
        rd_en3 = 1'b1; addr3 = 3'd3;
        step();
        rd_en3 = 1'b0;
        chk("d3_addr_err_pulse", addr_err3, 1'b0);
        chk("d3_mask_kept", rdata3, 8'h3C);
        chk("d3_status", status3, 24'h0);
        // asynchronous reset mid-pulse
        wr(2'd3, 8'h11);
        fault_raw[5] = 1'b1;
        repeat (3) step();
        fault_raw[5] = 1'b0;
        step();
        chk("arst_pre_intb", intb_o, 1'b0);
        chk("arst_pre_status", status, 16'h0020);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_intb", intb_o, 1'b1);
        chk("arst_status", status, 16'h0);
        chk("arst_mask", dut.mask_q, 16'h0000);
        chk("arst_mask3", dut3.mask_q, 24'h0000F0);
        chk("arst_pend", flt_pend, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_intb", intb_o, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
